// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low segment patterns (seg[6]=CA .. seg[0]=CG)
// and the nibble-to-pattern mapping used by the scan multiplexer.
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Decimal mode has no glyph for A-F, so those nibbles go dark.
    function automatic seg_t nib_to_seg(input logic [3:0] nib, input logic hex);
        seg_t pat;
        case (nib)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = hex ? SEG_A : SEG_BLANK;
            4'hB:    pat = hex ? SEG_B : SEG_BLANK;
            4'hC:    pat = hex ? SEG_C : SEG_BLANK;
            4'hD:    pat = hex ? SEG_D : SEG_BLANK;
            4'hE:    pat = hex ? SEG_E : SEG_BLANK;
            default: pat = hex ? SEG_F : SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble decoder: one digit's nibble plus display mode to an
// active-low segment pattern.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    always_comb begin
        seg = nib_to_seg(nibble, hex_mode);
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed seven-segment driver: scans N_DIGITS common-anode digits,
// double-buffers loads so the visible data only changes between frames.
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    hex_mode,
    input  logic                    lzb_en,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  slot_tick;
    logic                  wrap_tick;

    logic [4*N_DIGITS-1:0] disp_value;
    logic [N_DIGITS-1:0]   disp_dp;
    logic                  disp_hex;
    logic                  disp_lzb;

    logic [4*N_DIGITS-1:0] pend_value;
    logic [N_DIGITS-1:0]   pend_dp;
    logic                  pend_hex;
    logic                  pend_lzb;
    logic                  pend_valid;

    logic [3:0]            sel_nib;
    logic [6:0]            dec_seg;
    logic [N_DIGITS-1:0]   lead_zero;
    logic                  in_blank;
    logic                  digit_blank;

    logic [6:0]            seg_d;
    logic                  dp_n_d;
    logic [N_DIGITS-1:0]   an_d;

    assign slot_tick = (cnt == CNT_LAST);
    assign wrap_tick = slot_tick && (idx == IDX_LAST);

    // Prescaler and digit index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap_tick;
            if (slot_tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A load on the wrap tick bypasses the pending stage so it is not held a
    // whole extra frame; otherwise pending data is promoted only at the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_hex   <= 1'b0;
            pend_lzb   <= 1'b0;
            pend_valid <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_hex   <= 1'b0;
            disp_lzb   <= 1'b0;
        end else if (wrap_tick) begin
            pend_valid <= 1'b0;
            if (load) begin
                disp_value <= value;
                disp_dp    <= dp;
                disp_hex   <= hex_mode;
                disp_lzb   <= lzb_en;
            end else if (pend_valid) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
                disp_hex   <= pend_hex;
                disp_lzb   <= pend_lzb;
            end
        end else if (load) begin
            pend_value <= value;
            pend_dp    <= dp;
            pend_hex   <= hex_mode;
            pend_lzb   <= lzb_en;
            pend_valid <= 1'b1;
        end
    end

    assign sel_nib = disp_value[{idx, 2'b00} +: 4];

    ssd_hex_decode u_decode (
        .nibble   (sel_nib),
        .hex_mode (disp_hex),
        .seg      (dec_seg)
    );

    // lead_zero[i] is set when nibbles N_DIGITS-1 down to i are all zero.
    always_comb begin
        logic run;
        lead_zero = '0;
        run       = 1'b1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            run = run && (disp_value[4*(N_DIGITS-1-k) +: 4] == 4'h0);
            lead_zero[N_DIGITS-1-k] = run;
        end
    end

    assign in_blank    = (cnt < BLANK_LIM);
    assign digit_blank = disp_lzb && (idx != '0) && lead_zero[idx];

    always_comb begin
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        an_d   = '1;
        if (enable && !in_blank) begin
            an_d[idx] = 1'b0;
            seg_d     = digit_blank ? SEG_BLANK : dec_seg;
            dp_n_d    = ~disp_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
            an   <= '1;
        end else begin
            seg  <= seg_d;
            dp_n <= dp_n_d;
            an   <= an_d;
        end
    end

endmodule

// File: doc/ssd_scan_mux.md
SSD_SCAN_MUX -- requirements
Module: ssd_scan_mux

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot, minimum 4.
REQ-003 Parameter BLANK_CYC, default 2: anti-ghost cycles at the start of each slot, less than REFRESH_DIV.
REQ-004 Port clk, input, 1: single clock; every register samples on its rising edge.
REQ-005 Port rst_n, input, 1: reset; it is synchronous and active-low.
REQ-006 Port enable, input, 1: 1 = drive display; 0 = all anodes off, scan keeps running.
REQ-007 Port load, input, 1: one-cycle strobe that captures value, dp, hex_mode and lzb_en.
REQ-008 Port value, input, 4*N_DIGITS: nibble i is digit i; digit 0 is least significant and rightmost.
REQ-009 Port dp, input, N_DIGITS: decimal-point request per digit, 1 = lit.
REQ-010 Port hex_mode, input, 1: 1 = nibbles 0-F shown as hex; 0 = decimal, nibbles A-F blanked.
REQ-011 Port lzb_en, input, 1: leading-zero blanking enable.
REQ-012 Port seg, output, 7: active-low segments; seg[6]=CA through seg[0]=CG.
REQ-013 Port dp_n, output, 1: active-low decimal point.
REQ-014 Port an, output, N_DIGITS: active-low digit anodes, at most one low at any time.
REQ-015 Port frame_done, output, 1: one-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0.

Function
REQ-016 Prescaler counts 0..REFRESH_DIV-1 and wraps; slot_tick is asserted when the count equals REFRESH_DIV-1.
REQ-017 Digit index increments on slot_tick and wraps from N_DIGITS-1 to 0; frame_done is registered high in the cycle after that wrap tick.
REQ-018 On load, inputs are captured into a pending register and a pending flag is set; back-to-back loads leave only the last one pending.
REQ-019 On the wrap tick, pending data moves to the display register and the pending flag clears; the display never changes mid-frame.
REQ-020 When load coincides with the wrap tick, the new load data goes straight to the display register and the pending flag clears.
REQ-021 Decode: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-022 Hex decode: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000; blank=1111111.
REQ-023 Leading-zero blanking: digit i>0 is blanked when lzb_en=1 and nibbles N_DIGITS-1..i are all 0; digit 0 is never blanked by this rule.
REQ-024 A blanked digit keeps its anode low with seg=1111111; its dp still follows the display dp bit.
REQ-025 For prescaler counts below BLANK_CYC, all anodes are high and seg=1111111.
REQ-026 seg, dp_n and an are registered: they reflect the index and prescaler values of the previous cycle (1-cycle latency).
REQ-027 When enable=0: an is all ones, seg=1111111 and dp_n=1; the prescaler, index, load and frame_done logic run unchanged.

Reset
REQ-028 While rst_n=0 at a clock edge:
- prescaler, index, display register, pending register and pending flag clear to 0;
- seg=1111111, dp_n=1, an=all ones, frame_done=0.
REQ-029 Reset mid-frame discards any pending load; scanning restarts at digit 0, prescaler 0, on the first edge with rst_n=1.

Structure
REQ-030 Shared package ssd_pkg holds the 16 segment-pattern constants, SEG_BLANK and the nibble-to-segment function.
REQ-031 Combinational sub-module ssd_hex_decode maps nibble and hex_mode to a 7-bit pattern; ssd_scan_mux instantiates it once, on the selected digit.

Verification (N_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1)
REQ-032 Hold rst_n=0 for 3 cycles -> seg=1111111, an=1111, dp_n=1, frame_done=0 throughout.
REQ-033 Load value=16'h1234, dp=0001, hex_mode=0 -> after the next frame_done:
- digit 0 slot: an=1110, seg=1001100, dp_n=0;
- digit 3 slot: an=0111, seg=1001111.
REQ-034 Load value=16'h0007 with lzb_en=1 -> digits 1-3 show seg=1111111; digit 0 shows 0001111.
REQ-035 Load value=16'h00A0:
- hex_mode=0 -> digit 1 slot shows seg=1111111;
- hex_mode=1 -> digit 1 slot shows seg=0001000.
REQ-036 Load value=16'h5555 during the digit 1 slot -> the remaining slots of that frame show the old data; the whole next frame shows seg=0100100.
REQ-037 Additional directed cases:
- load on the exact wrap cycle -> new data appears in that next frame;
- rst_n=0 pulse mid-frame -> all outputs take reset values, then scanning restarts at digit 0.
